sync_demod: RTL and testbench
=============================

Name: sync_demod

Overview:
Synchronous square-wave demodulator with integrate-and-dump low-pass filtering.
It sits directly upstream of the loop PI controller and converts the raw ADC pickoff samples into a baseband error amplitude.
Each accepted sample is multiplied by ±1 according to the reference phase bit and accumulated over exactly 2^ACC_LEN_LOG2 samples, aligned to a reference rising edge.
The mean is then dumped to a held 32-bit signed output, which the PI stage consumes as its input signal.

Parameters:
DATA_W, 16, ADC sample width (signed two's complement)
ACC_LEN_LOG2, 6, log2 of samples per dump window (N = 64)
OUT_W, 32, output width; must be ≥ DATA_W+1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en_i  in  1  demodulator enable; low = idle, accumulator cleared
adc_valid_i  in  1  sample strobe; adc_data_i/ref_sq_i qualified by it
adc_data_i  in  DATA_W  signed ADC sample
ref_sq_i  in  1  reference square wave: 1 = +1 phase, 0 = -1 phase
demod_o  out  OUT_W  signed demodulated mean, held between dumps
demod_valid_o  out  1  one-cycle pulse when demod_o updates

Behaviour:
- Reset (async, rst_n low): state=IDLE, acc=0, cnt=0, ref_prev=0, demod_o=0, demod_valid_o=0. This applies immediately, including mid-window; the partial window is discarded.
- Accumulator width is DATA_W+ACC_LEN_LOG2+1 signed, so it cannot overflow; -2^(DATA_W-1) negation is exact.
- ref_prev is updated with ref_sq_i only on adc_valid_i cycles.
- States:
  - IDLE:
    - Entered on reset, or on any cycle with en_i=0, from any state.
    - When en_i=0: acc and cnt are cleared synchronously; demod_o holds its last value; no pulse.
    - Transition to ALIGN when en_i=1.
  - ALIGN:
    - Waits for a reference rising edge: adc_valid_i=1, ref_sq_i=1 and ref_prev=0.
    - That edge sample is the first sample of the window: acc <= +x, cnt <= 1, go to ACCUM.
    - Any other sample is discarded.
    - For N=1, dump rules apply on the edge sample itself.
  - ACCUM:
    - On each adc_valid_i: term = ref_sq_i ? +x : -x; acc <= acc+term; cnt <= cnt+1.
    - On the Nth sample (cnt==N-1 with adc_valid_i):
      - demod_o <= sign-extend((acc+term) >>> ACC_LEN_LOG2), arithmetic shift, floor rounding.
      - demod_valid_o <= 1 for exactly one cycle.
      - acc <= 0, cnt <= 0.
      - Stay in ACCUM; no re-alignment. Windows are back-to-back and no sample is lost.
    - Cycles without adc_valid_i: acc and cnt hold. Gaps of any length are allowed.
- Latency: demod_o/demod_valid_o update on the clock edge after the Nth sample is presented, i.e. visible 1 cycle later.
- Simultaneous events:
  - en_i=0 overrides everything, including a completing Nth sample: no dump, no pulse.
  - Rising edge of ref_sq_i inside ACCUM is ignored; alignment happens only once per enable.
- demod_o is never cleared except by reset. The PI stage sees a stable, continuously driven value.
- cnt is ACC_LEN_LOG2 bits wide and wraps naturally at the dump.

Decomposition:
- Shared package gysc_pkg:
  - state enum (IDLE, ALIGN, ACCUM);
  - default ADC width 16;
  - loop data width 32, shared with the PI controller;
  - default ACC_LEN_LOG2.
- No sub-module is needed. The rising-edge detect is a single register and stays inline.

Test Plan:
1. In-phase signal: x=+1000 while ref=1 (32 samples), x=-1000 while ref=0 (32 samples), adc_valid every cycle, en=1 → first pulse 1 cycle after sample 64, demod_o=1000; repeat windows each give 1000.
2. Quadrature signal: x=+1000 for the first 16 samples of each ref half and -1000 for the next 16 → demod_o=0 at every dump. Constant x=1000 also gives demod_o=0.
3. Full scale: x=-32768 while ref=1, x=+32767 while ref=0 → acc=-2097120, demod_o=-32768 (floor), no overflow.
4. Sparse valid: adc_valid one cycle in 5, in-phase ±500 → pulse only after 64 accepted samples (~320 cycles), demod_o=500.
5. Alignment: enable with ref=1 already high → no accumulation until a 0→1 transition on a valid sample; the first window starts exactly at that sample.
6. Abort: rst_n low at sample 40 → all outputs 0 immediately. Separately, en_i low at sample 63 → no pulse, demod_o keeps its previous value, and the block re-aligns after en_i returns high.

Source files
------------

// File: rtl/gysc_pkg.sv
// gysc_pkg: shared types and widths for the sync demodulator
// and the downstream loop stages (PI controller).
package gysc_pkg;

   // Demodulator control states.
   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      ACCUM
   } demod_state_t;

   // Default ADC sample width.
   localparam int ADC_W = 16;

   // Loop data width, shared with the PI controller.
   localparam int LOOP_W = 32;

   // Default log2 of the dump window length.
   localparam int ACC_LEN_LOG2_DEF = 6;

endpackage

// File: rtl/sync_demod.sv
// sync_demod: square-wave synchronous demodulator with
// integrate-and-dump over 2^ACC_LEN_LOG2 reference-aligned samples.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   en_i           enable; low clears acc/cnt and forces IDLE
//   adc_valid_i    qualifies adc_data_i and ref_sq_i
//   adc_data_i     signed ADC sample
//   ref_sq_i       reference phase: 1 = +1, 0 = -1
//   demod_o        signed window mean, held between dumps
//   demod_valid_o  one-cycle pulse when demod_o updates
module sync_demod
   import gysc_pkg::*;
#(
   parameter int DATA_W       = ADC_W,
   parameter int ACC_LEN_LOG2 = ACC_LEN_LOG2_DEF,
   parameter int OUT_W        = LOOP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              adc_valid_i,
   input  logic [DATA_W-1:0] adc_data_i,
   input  logic              ref_sq_i,
   output logic [OUT_W-1:0]  demod_o,
   output logic              demod_valid_o
);

   // One guard bit beyond the window growth makes
   // negating the most negative sample exact.
   localparam int ACC_W = DATA_W + ACC_LEN_LOG2 + 1;
   localparam int CNT_W = (ACC_LEN_LOG2 > 0) ? ACC_LEN_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((1 << ACC_LEN_LOG2) - 1);

   demod_state_t            state;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;
   logic                    ref_prev;

   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] term;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] mean;
   logic                    rise;
   logic                    take;
   logic                    last;

   always_comb begin
      x_ext = {{(ACC_W-DATA_W){adc_data_i[DATA_W-1]}},
               adc_data_i};
      term  = ref_sq_i ? x_ext : -x_ext;
      // acc is zero while aligning, so the edge sample
      // shares the same add path as ACCUM samples.
      sum   = acc + term;
      mean  = sum >>> ACC_LEN_LOG2;
      last  = (cnt == CNT_LAST);
      rise  = ref_sq_i && !ref_prev;
      take  = 1'b0;
      if (en_i && adc_valid_i) begin
         unique case (state)
            ALIGN:   take = rise;
            ACCUM:   take = 1'b1;
            default: take = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         ref_prev      <= 1'b0;
         demod_o       <= '0;
         demod_valid_o <= 1'b0;
      end else begin
         demod_valid_o <= 1'b0;
         if (adc_valid_i) ref_prev <= ref_sq_i;
         if (!en_i) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
         end else begin
            unique case (state)
               IDLE:    state <= ALIGN;
               ALIGN:   if (take) state <= ACCUM;
               ACCUM:   state <= ACCUM;
               default: state <= IDLE;
            endcase
            if (take) begin
               if (last) begin
                  acc           <= '0;
                  cnt           <= '0;
                  demod_o       <= OUT_W'(mean);
                  demod_valid_o <= 1'b1;
               end else begin
                  acc <= sum;
                  cnt <= cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sync_demod.sv
// tb_sync_demod: directed + randomized bench for sync_demod
// against a window-sum reference model.
module tb_sync_demod;

   localparam int N = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_i = 1'b0;
   logic        adc_valid_i = 1'b0;
   logic [15:0] adc_data_i = '0;
   logic        ref_sq_i = 1'b0;
   logic [31:0] demod_o;
   logic        demod_valid_o;

   sync_demod dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en_i          (en_i),
      .adc_valid_i   (adc_valid_i),
      .adc_data_i    (adc_data_i),
      .ref_sq_i      (ref_sq_i),
      .demod_o       (demod_o),
      .demod_valid_o (demod_valid_o)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;
   int npulse = 0;
   int ph = 0;

   // Reference model: "armed" = enabled for at least one
   // edge, "locked" = window alignment found.
   bit     m_armed;
   bit     m_locked;
   bit     m_refp;
   longint m_sum;
   int     m_n;
   int     exp_out;
   bit     exp_pulse;

   task automatic model_reset();
      m_armed   = 0;
      m_locked  = 0;
      m_refp    = 0;
      m_sum     = 0;
      m_n       = 0;
      exp_out   = 0;
      exp_pulse = 0;
   endtask

   function automatic int floor_div(longint s);
      longint q;
      q = s / N;
      if ((s % N) != 0 && s < 0) q = q - 1;
      return int'(q);
   endfunction

   task automatic model_step(bit e, bit v, int x, bit r);
      exp_pulse = 0;
      if (!e) begin
         m_armed  = 0;
         m_locked = 0;
         m_sum    = 0;
         m_n      = 0;
      end else if (!m_armed) begin
         m_armed = 1;
      end else if (v && (m_locked || (r && !m_refp))) begin
         m_locked = 1;
         m_sum = m_sum + (r ? x : -x);
         m_n++;
         if (m_n == N) begin
            exp_out   = floor_div(m_sum);
            exp_pulse = 1;
            m_sum     = 0;
            m_n       = 0;
         end
      end
      if (v) m_refp = r;
   endtask

   task automatic cyc(bit e, bit v, logic [15:0] x, bit r);
      en_i        = e;
      adc_valid_i = v;
      adc_data_i  = x;
      ref_sq_i    = r;
      @(posedge clk);
      model_step(e, v, int'($signed(x)), r);
      #1;
      if (demod_valid_o === 1'b1) npulse++;
      ncmp++;
      assert (demod_valid_o === exp_pulse) else begin
         nerr++;
         $error("FAIL pulse obs=%0b exp=%0b t=%0t",
                demod_valid_o, exp_pulse, $time);
      end
      ncmp++;
      assert (demod_o === exp_out) else begin
         nerr++;
         $error("FAIL demod obs=%0d exp=%0d t=%0t",
                $signed(demod_o), exp_out, $time);
      end
   endtask

   // kind: 0 in-phase, 1 quadrature, 2 constant,
   // 3 full scale, 4 random data. gap<0: random gap.
   task automatic feed(int kind, int amp, int ns, int gap);
      bit          r;
      int          g;
      logic [15:0] x;
      for (int i = 0; i < ns; i++) begin
         g = (gap < 0) ? int'($urandom_range(2)) : gap;
         for (int k = 0; k < g; k++)
            cyc(1, 0, 16'($urandom), 1'($urandom));
         r = ((ph % N) < N/2);
         case (kind)
            0: x = 16'(r ? amp : -amp);
            1: x = 16'(((ph % (N/2)) < N/4) ? amp : -amp);
            2: x = 16'(amp);
            3: x = r ? 16'h8000 : 16'h7fff;
            default: x = 16'($urandom);
         endcase
         cyc(1, 1, x, r);
         ph++;
      end
   endtask

   task automatic chk(string tag, int obs, int exp_v);
      ncmp++;
      assert (obs === exp_v) else begin
         nerr++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
      end
   endtask

   int p0;

   initial begin
      model_reset();
      #12;
      chk("rst_demod", int'(demod_o), 0);
      chk("rst_valid", int'(demod_valid_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 1, 16'd7, 0);
      cyc(0, 1, 16'd9, 0);

      // In-phase: align at ph=64, three windows.
      ph = 32;
      p0 = npulse;
      feed(0, 1000, 32 + 3*N, 0);
      chk("inphase_val", int'($signed(demod_o)), 1000);
      chk("inphase_cnt", npulse - p0, 3);

      // Quadrature and constant input reject.
      feed(1, 1000, 2*N, 0);
      chk("quad_val", int'($signed(demod_o)), 0);
      feed(0, 1000, N, 0);
      feed(2, 1000, N, 0);
      chk("const_val", int'($signed(demod_o)), 0);

      // Full scale, floor rounding.
      feed(3, 0, N, 0);
      chk("fullscale", int'($signed(demod_o)), -32768);

      // Sparse valid, one cycle in five.
      p0 = npulse;
      feed(0, 500, N - 1, 4);
      chk("sparse_early", npulse - p0, 0);
      feed(0, 500, 1, 4);
      chk("sparse_val", int'($signed(demod_o)), 500);
      chk("sparse_cnt", npulse - p0, 1);

      // Enable drop on the 64th sample.
      p0 = npulse;
      feed(0, 300, N - 1, 0);
      cyc(0, 1, 16'(-300), 0);
      ph++;
      chk("abort_cnt", npulse - p0, 0);
      chk("abort_hold", int'($signed(demod_o)), 500);
      feed(0, 300, 2*N, 0);
      chk("realign_val", int'($signed(demod_o)), 300);

      // Enable while reference already high.
      for (int i = 0; i < 4; i++) cyc(0, 1, 16'd1, 1);
      ph = 5;
      p0 = npulse;
      feed(4, 0, N - 5 + N - 1, 0);
      chk("align_early", npulse - p0, 0);
      feed(4, 0, 1 + N, 0);
      chk("align_cnt", npulse - p0, 2);

      // Randomized data, gaps and occasional disable.
      for (int b = 0; b < 6; b++) begin
         feed(4, 0, 150, -1);
         if ($urandom_range(1) == 1) begin
            cyc(0, 1, 16'($urandom), 1'($urandom));
            ph = int'($urandom_range(63));
         end
      end

      // Async reset mid-window (sample 40).
      for (int i = 0; i < 2; i++) cyc(0, 1, 16'd0, 0);
      ph = 32;
      feed(0, 700, 32 + N + 40, 0);
      chk("pre_rst", int'($signed(demod_o)), 700);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_demod", int'(demod_o), 0);
      chk("arst_valid", int'(demod_valid_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ph = 32;
      feed(0, 1234, 32 + N, 0);
      chk("post_rst", int'($signed(demod_o)), 1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
